// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read, dual-write register file with a per-register busy scoreboard.
// Reset loads each register with its own index; wb0 wins over wb1 on an address collision.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 15,
   parameter int NUM_RD   = 3,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wb0_en,
   input  logic [ADDR_W-1:0]        wb0_addr,
   input  logic [DATA_W-1:0]        wb0_data,
   input  logic                     wb1_en,
   input  logic [ADDR_W-1:0]        wb1_addr,
   input  logic [DATA_W-1:0]        wb1_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     any_busy,
   output logic                     wr_conflict
);
   localparam logic BYP = BYPASS != 0;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy, w0_hit, w1_hit, iss_hit;
   // One-hot decodes only cover implemented registers, so out-of-range addresses fall away naturally
   always_comb begin
      w0_hit  = '0;
      w1_hit  = '0;
      iss_hit = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w0_hit[r]  = wb0_en && wb0_addr == ADDR_W'(r);
         w1_hit[r]  = wb1_en && wb1_addr == ADDR_W'(r);
         iss_hit[r] = iss_en && iss_addr == ADDR_W'(r);
      end
   end
   assign wr_conflict = |(w0_hit & w1_hit);
   assign any_busy    = |busy;
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i);
         busy <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w0_hit[r]) regs[r] <= wb0_data;
            else if (w1_hit[r]) regs[r] <= wb1_data;
         end
         busy <= iss_hit | (busy & ~(w0_hit | w1_hit));
      end
   end
   // A new issue outranks a same-cycle writeback: that producer is still outstanding
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
               rd_data[k*DATA_W +: DATA_W] = (BYP && w0_hit[r]) ? wb0_data :
                                             (BYP && w1_hit[r]) ? wb1_data : regs[r];
               rd_busy[k] = busy[r] && !(BYP && (w0_hit[r] || w1_hit[r]));
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives a bypassing and a non-bypassing instance in lockstep against an array model.
module tb_reg_file_mp;
   localparam int NR = 15;
   logic        clk = 0, rst;
   logic [11:0] rd_addr;
   logic        wb0_en, wb1_en, iss_en;
   logic [3:0]  wb0_addr, wb1_addr, iss_addr;
   logic [31:0] wb0_data, wb1_data;
   logic [95:0] rd_data1, rd_data0;
   logic [2:0]  rd_busy1, rd_busy0;
   logic        any_busy1, any_busy0, conf1, conf0;
   logic [31:0] mem [NR];
   logic [NR-1:0] bsy;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.BYPASS(1)) d1 (.clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_busy(rd_busy1), .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
      .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .any_busy(any_busy1), .wr_conflict(conf1));
   reg_file_mp #(.BYPASS(0)) d0 (.clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_busy(rd_busy0), .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
      .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .any_busy(any_busy0), .wr_conflict(conf0));

   function automatic logic [31:0] exp_data(int a, bit byp);
      if (a >= NR) return 0;
      if (byp && wb0_en && int'(wb0_addr) == a) return wb0_data;
      if (byp && wb1_en && int'(wb1_addr) == a) return wb1_data;
      return mem[a];
   endfunction

   function automatic logic exp_busy(int a, bit byp);
      if (a >= NR) return 0;
      return bsy[a] && !(byp && ((wb0_en && int'(wb0_addr) == a) || (wb1_en && int'(wb1_addr) == a)));
   endfunction

   task automatic chk(string tag, int port, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, port, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         int a;
         a = int'(rd_addr[k*4 +: 4]);
         chk("rd_data_byp", k, rd_data1[k*32 +: 32], exp_data(a, 1));
         chk("rd_data_nobyp", k, rd_data0[k*32 +: 32], exp_data(a, 0));
         chk("rd_busy_byp", k, 32'(rd_busy1[k]), 32'(exp_busy(a, 1)));
         chk("rd_busy_nobyp", k, 32'(rd_busy0[k]), 32'(exp_busy(a, 0)));
      end
      chk("any_busy_byp", 0, 32'(any_busy1), 32'(|bsy));
      chk("any_busy_nobyp", 0, 32'(any_busy0), 32'(|bsy));
      chk("wr_conflict", 0, 32'(conf1), 32'(wb0_en && wb1_en && wb0_addr == wb1_addr && int'(wb0_addr) < NR));
      chk("wr_conflict_nobyp", 0, 32'(conf0), 32'(wb0_en && wb1_en && wb0_addr == wb1_addr && int'(wb0_addr) < NR));
   endtask

   // Model: clear by writebacks first, then a same-cycle issue sets (issue wins)
   task automatic model_edge();
      if (!rst) begin
         for (int i = 0; i < NR; i++) mem[i] = 32'(i);
         bsy = '0;
      end else begin
         if (wb1_en && int'(wb1_addr) < NR) begin mem[wb1_addr] = wb1_data; bsy[wb1_addr] = 0; end
         if (wb0_en && int'(wb0_addr) < NR) begin mem[wb0_addr] = wb0_data; bsy[wb0_addr] = 0; end
         if (iss_en && int'(iss_addr) < NR) bsy[iss_addr] = 1;
      end
   endtask

   task automatic tick();
      #1;
      if (rst) check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wb0_en = 0; wb1_en = 0; iss_en = 0;
   endtask

   task automatic rd(int a0, int a1, int a2);
      rd_addr = {4'(a2), 4'(a1), 4'(a0)};
   endtask

   task automatic wb0(int a, logic [31:0] d);
      wb0_en = 1; wb0_addr = 4'(a); wb0_data = d;
   endtask

   task automatic wb1(int a, logic [31:0] d);
      wb1_en = 1; wb1_addr = 4'(a); wb1_data = d;
   endtask

   task automatic iss(int a);
      iss_en = 1; iss_addr = 4'(a);
   endtask

   initial begin
      rst = 0; idle(); rd(0, 0, 0);
      wb0_addr = 0; wb1_addr = 0; iss_addr = 0; wb0_data = 0; wb1_data = 0;
      tick(); tick();
      rst = 1;
      for (int a = 0; a < 16; a++) begin rd(a, (a + 5) % 16, 15 - a); tick(); end
      // same-cycle bypass, then the stored value
      wb0(3, 32'hDEADBEEF); rd(3, 3, 4); tick();
      idle(); tick();
      // both ports to r5
      wb0(5, 32'h11); wb1(5, 32'h22); rd(5, 6, 5); tick();
      idle(); tick();
      // scoreboard set at issue, cleared by wb1 writeback
      iss(7); rd(7, 7, 0); tick();
      idle(); tick(); tick(); tick();
      wb1(7, 32'h77); tick();
      idle(); tick();
      // issue and writeback to r2 together
      iss(2); wb0(2, 32'h2222); rd(2, 2, 7); tick();
      idle(); tick();
      wb0(2, 32'h3333); tick();
      idle(); tick();
      // out-of-range writes and issue are ignored
      wb0(15, 32'hAAAA); wb1(15, 32'hBBBB); iss(15); rd(15, 0, 1); tick();
      idle(); tick();
      // mid-operation reset
      iss(1); rd(1, 9, 0); tick();
      iss(9); tick();
      idle(); wb0(9, 32'hFF); tick();
      idle(); rst = 0; tick();
      rst = 1; rd(9, 1, 0); tick();
      repeat (400) begin
         rst = ($urandom_range(0, 49) != 0);
         wb0_en = 1'($urandom); wb0_addr = 4'($urandom); wb0_data = $urandom;
         wb1_en = 1'($urandom); wb1_addr = ($urandom_range(0, 3) == 0) ? wb0_addr : 4'($urandom);
         wb1_data = $urandom;
         iss_en = 1'($urandom); iss_addr = 4'($urandom);
         rd_addr = 12'($urandom);
         tick();
      end
      rst = 1; idle(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
